// File: rtl/fp_pkg.sv
// Shared format codes, fclass bit positions and pre-decode flag layout
// for the FP min/max operand-preparation path.
package fp_pkg;

  localparam logic [1:0] FMT_S = 2'd0;
  localparam logic [1:0] FMT_D = 2'd1;

  localparam int CLS_W    = 10;
  localparam int CLS_NINF = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF = 7;
  localparam int CLS_SNAN = 8;
  localparam int CLS_QNAN = 9;

  localparam logic [63:0] CANON_NAN_D = 64'h7ff8000000000000;
  localparam logic [63:0] CANON_NAN_S = 64'h000000007fc00000;

  typedef struct packed {
    logic sign;
    logic exp_all_ones;
    logic exp_zero;
    logic mant_zero;
    logic quiet;
  } pre_flags_t;

  function automatic logic fmt_reserved(input logic [1:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Per-operand classifier split in two halves: a field pre-decode that runs on
// the raw input, and a final ext/class assembly that runs on registered data.
module fp_classify
  import fp_pkg::*;
(
  input  logic [63:0]      pre_data,
  input  logic [1:0]       pre_fmt,
  output pre_flags_t       pre_flags,
  input  logic [63:0]      data,
  input  logic [1:0]       fmt,
  input  pre_flags_t       flags,
  output logic [64:0]      ext,
  output logic [CLS_W-1:0] cls,
  output logic             illegal
);

  logic is_nan;
  logic is_inf;
  logic is_zero;
  logic is_sub;
  logic is_norm;

  // Reserved formats decode as single here; the final half masks them out.
  always_comb begin
    pre_flags = '0;
    if (pre_fmt == FMT_D) begin
      pre_flags.sign         = pre_data[63];
      pre_flags.exp_all_ones = &pre_data[62:52];
      pre_flags.exp_zero     = ~|pre_data[62:52];
      pre_flags.mant_zero    = ~|pre_data[51:0];
      pre_flags.quiet        = pre_data[51];
    end else begin
      pre_flags.sign         = pre_data[31];
      pre_flags.exp_all_ones = &pre_data[30:23];
      pre_flags.exp_zero     = ~|pre_data[30:23];
      pre_flags.mant_zero    = ~|pre_data[22:0];
      pre_flags.quiet        = pre_data[22];
    end
  end

  assign is_nan  = flags.exp_all_ones & ~flags.mant_zero;
  assign is_inf  = flags.exp_all_ones & flags.mant_zero;
  assign is_zero = flags.exp_zero & flags.mant_zero;
  assign is_sub  = flags.exp_zero & ~flags.mant_zero;
  assign is_norm = ~flags.exp_all_ones & ~flags.exp_zero;

  assign illegal = fmt_reserved(fmt);

  // The gap bits keep ext[63:0] an unsigned magnitude for either format.
  always_comb begin
    ext = '0;
    case (fmt)
      FMT_S:   ext = {data[31], 33'b0, data[30:0]};
      FMT_D:   ext = {data[63], 1'b0, data[62:0]};
      default: ext = '0;
    endcase
  end

  always_comb begin
    cls = '0;
    if (!illegal) begin
      if (is_nan) begin
        if (flags.quiet) cls[CLS_QNAN] = 1'b1;
        else             cls[CLS_SNAN] = 1'b1;
      end else if (is_inf) begin
        if (flags.sign) cls[CLS_NINF] = 1'b1;
        else            cls[CLS_PINF] = 1'b1;
      end else if (is_zero) begin
        if (flags.sign) cls[CLS_NZERO] = 1'b1;
        else            cls[CLS_PZERO] = 1'b1;
      end else if (is_sub) begin
        if (flags.sign) cls[CLS_NSUB] = 1'b1;
        else            cls[CLS_PSUB] = 1'b1;
      end else if (is_norm) begin
        if (flags.sign) cls[CLS_NNORM] = 1'b1;
        else            cls[CLS_PNORM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_minmax_prep.sv
// Two-stage operand preparation for the FP min/max unit: S1 captures inputs
// plus field pre-decode, S2 holds the final extended values and class vectors.
module fp_minmax_prep
  import fp_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fp_prep_i_flush,
  input  logic             fp_prep_i_valid,
  output logic             fp_prep_o_ready,
  input  logic [63:0]      fp_prep_i_data1,
  input  logic [63:0]      fp_prep_i_data2,
  input  logic [1:0]       fp_prep_i_fmt,
  input  logic [2:0]       fp_prep_i_rm,
  input  logic [TAG_W-1:0] fp_prep_i_tag,
  output logic             fp_prep_o_valid,
  input  logic             fp_prep_i_ready,
  output logic [63:0]      fp_prep_o_data1,
  output logic [63:0]      fp_prep_o_data2,
  output logic [64:0]      fp_prep_o_ext1,
  output logic [64:0]      fp_prep_o_ext2,
  output logic [CLS_W-1:0] fp_prep_o_class1,
  output logic [CLS_W-1:0] fp_prep_o_class2,
  output logic [1:0]       fp_prep_o_fmt,
  output logic [2:0]       fp_prep_o_rm,
  output logic [TAG_W-1:0] fp_prep_o_tag,
  output logic             fp_prep_o_illegal
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic             s1_load;
  logic             s2_load;

  logic [63:0]      s1_data1;
  logic [63:0]      s1_data2;
  logic [1:0]       s1_fmt;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;
  pre_flags_t       s1_flags1;
  pre_flags_t       s1_flags2;
  pre_flags_t       pre_flags1;
  pre_flags_t       pre_flags2;

  logic [64:0]      ext1_d;
  logic [64:0]      ext2_d;
  logic [CLS_W-1:0] cls1_d;
  logic [CLS_W-1:0] cls2_d;
  logic             ill1_d;
  logic             ill2_d;

  // Ready looks only at stage occupancy and downstream ready, never at i_valid.
  assign s2_adv          = !s2_valid || fp_prep_i_ready;
  assign s1_adv          = !s1_valid || s2_adv;
  assign fp_prep_o_ready = s1_adv;
  assign accept          = fp_prep_i_valid && s1_adv && !fp_prep_i_flush;
  assign s1_load         = accept;
  assign s2_load         = s2_adv && s1_valid && !fp_prep_i_flush;
  assign fp_prep_o_valid = s2_valid;

  fp_classify u_cls1 (
    .pre_data  (fp_prep_i_data1),
    .pre_fmt   (fp_prep_i_fmt),
    .pre_flags (pre_flags1),
    .data      (s1_data1),
    .fmt       (s1_fmt),
    .flags     (s1_flags1),
    .ext       (ext1_d),
    .cls       (cls1_d),
    .illegal   (ill1_d)
  );

  fp_classify u_cls2 (
    .pre_data  (fp_prep_i_data2),
    .pre_fmt   (fp_prep_i_fmt),
    .pre_flags (pre_flags2),
    .data      (s1_data2),
    .fmt       (s1_fmt),
    .flags     (s1_flags2),
    .ext       (ext2_d),
    .cls       (cls2_d),
    .illegal   (ill2_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (fp_prep_i_flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= fp_prep_i_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data1  <= '0;
      s1_data2  <= '0;
      s1_fmt    <= '0;
      s1_rm     <= '0;
      s1_tag    <= '0;
      s1_flags1 <= '0;
      s1_flags2 <= '0;
    end else if (s1_load) begin
      s1_data1  <= fp_prep_i_data1;
      s1_data2  <= fp_prep_i_data2;
      s1_fmt    <= fp_prep_i_fmt;
      s1_rm     <= fp_prep_i_rm;
      s1_tag    <= fp_prep_i_tag;
      s1_flags1 <= pre_flags1;
      s1_flags2 <= pre_flags2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (fp_prep_i_flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
    end
  end

  // Output registers only move on an S1->S2 transfer, so a stall holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_prep_o_data1   <= '0;
      fp_prep_o_data2   <= '0;
      fp_prep_o_ext1    <= '0;
      fp_prep_o_ext2    <= '0;
      fp_prep_o_class1  <= '0;
      fp_prep_o_class2  <= '0;
      fp_prep_o_fmt     <= '0;
      fp_prep_o_rm      <= '0;
      fp_prep_o_tag     <= '0;
      fp_prep_o_illegal <= 1'b0;
    end else if (s2_load) begin
      fp_prep_o_data1   <= s1_data1;
      fp_prep_o_data2   <= s1_data2;
      fp_prep_o_ext1    <= ext1_d;
      fp_prep_o_ext2    <= ext2_d;
      fp_prep_o_class1  <= cls1_d;
      fp_prep_o_class2  <= cls2_d;
      fp_prep_o_fmt     <= s1_fmt;
      fp_prep_o_rm      <= s1_rm;
      fp_prep_o_tag     <= s1_tag;
      fp_prep_o_illegal <= ill1_d | ill2_d;
    end
  end

endmodule

// File: doc/fp_minmax_prep.md
Name: fp_minmax_prep

Overview:
- Two-stage pipelined operand-preparation stage directly upstream of the FP min/max unit in the float execute path.
- Takes two raw operands plus format and rounding-mode fields, then produces per operand:
  - the original data,
  - a 65-bit sign/magnitude extended value,
  - a 10-bit class vector.
- Uses valid/ready handshakes on both sides and passes rm and a tag through unchanged.

Parameters:
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fp_prep_i_flush  in  1  synchronous flush; drops all in-flight ops
- fp_prep_i_valid  in  1  input operation valid
- fp_prep_o_ready  out  1  stage can accept an input this cycle
- fp_prep_i_data1  in  64  operand 1 (single precision: bits [31:0] used)
- fp_prep_i_data2  in  64  operand 2
- fp_prep_i_fmt  in  2  0 = single, 1 = double, 2/3 = reserved
- fp_prep_i_rm  in  3  min/max select (0 = min, 1 = max); passed through
- fp_prep_i_tag  in  TAG_W  sideband; passed through
- fp_prep_o_valid  out  1  output valid
- fp_prep_i_ready  in  1  downstream accepts
- fp_prep_o_data1, fp_prep_o_data2  out  64  operands as received
- fp_prep_o_ext1, fp_prep_o_ext2  out  65  extended operands
- fp_prep_o_class1, fp_prep_o_class2  out  10  class vectors
- fp_prep_o_fmt  out  2  pass-through
- fp_prep_o_rm  out  3  pass-through
- fp_prep_o_tag  out  TAG_W  pass-through
- fp_prep_o_illegal  out  1  fmt was reserved

Behaviour:
- Reset: all outputs and registers are 0 immediately when rst_n falls (asynchronous), so o_valid=0.
  - fp_prep_o_ready is combinational from register state, so it reads 1 while in reset.
  - The first accept can occur on the first clk edge after rst_n rises.
- Pipeline: S1 registers the inputs and pre-decode flags:
  - exp_all_ones, exp_zero, mant_zero, quiet bit, sign — for each operand.
  - S2 registers the final ext/class outputs.
  - Latency is 2 cycles accept-to-output; throughput is 1 op/cycle.
- Handshake:
  - s2_adv = !s2_valid | i_ready.
  - s1_adv = !s1_valid | s2_adv.
  - o_ready = s1_adv, combinational and with no dependence on i_valid.
  - Accept happens on i_valid & o_ready.
  - A stalled stage holds all its data stable, and o_valid never drops without a handshake.
- Flush: on the next edge s1_valid and s2_valid are cleared. An input presented in the same cycle is dropped. Flush has priority over accept.
- ext:
  - fmt=0: ext = {d[31], 33'b0, d[30:0]}.
  - fmt=1: ext = {d[63], 1'b0, d[62:0]}.
  - Unsigned compare of ext[63:0] orders magnitudes.
- Class bits (one-hot, RISC-V fclass order):
  - 0 = -inf, 1 = -normal, 2 = -subnormal, 3 = -zero
  - 4 = +zero, 5 = +subnormal, 6 = +normal, 7 = +inf
  - 8 = sNaN (exp all ones, mant!=0, quiet bit 0)
  - 9 = qNaN (quiet bit 1)
  - Single precision: exp = d[30:23], mant = d[22:0], quiet = d[22].
  - Double precision: exp = d[62:52], mant = d[51:0], quiet = d[51].
  - NaN class ignores sign.
- Reserved fmt (2/3):
  - class = 0, ext = 0, o_illegal = 1.
  - data, rm and tag are still passed through.
  - The op still flows through the pipeline.
- Simultaneous events: accept plus downstream drain in the same cycle keeps full throughput with no bubble. An S2 stall with S1 full deasserts o_ready.

Decomposition:
- Package fp_pkg holds:
  - FMT_S=0, FMT_D=1,
  - class bit index constants CLS_NINF..CLS_QNAN,
  - canonical NaNs (64'h7ff8000000000000, 64'h000000007fc00000).
- Sub-module fp_classify (combinational, one operand: data + fmt -> ext, class, illegal) is instantiated twice; its logic is split across S1/S2 via the pre-decode flags.

Test Plan:
- fmt=1, d1=64'h3FF0000000000000, d2=64'hBFF0000000000000, i_ready=1 -> o_valid 2 cycles later with:
  - ext1=65'h0_3FF0000000000000, class1=10'h040,
  - ext2=65'h1_3FF0000000000000, class2=10'h002.
- fmt=0, d1=32'h7F800001, d2=32'hFFC00000 -> class1=10'h100, ext1=65'h0_000000007F800001, class2=10'h200, ext2 bit64=1.
- fmt=0, d1=32'h80000000, d2=32'h00000001 -> class1=10'h008, class2=10'h020; fmt=1, d1=64'hFFF0000000000000 -> class1=10'h001.
- Back-to-back ops tags 1..5 with i_ready low for cycles 3-5:
  - o_ready falls once S1 and S2 are full,
  - outputs stay stable while stalled,
  - all 5 emerge in order with no loss or duplication.
- rst_n low while 2 ops are in flight -> o_valid=0 the same cycle, outputs 0; after release, a new op emerges after 2 cycles.
- flush with 2 ops in flight plus a new i_valid -> no outputs appear; o_illegal=1 for an fmt=2 op with class1=0.
